bus_invert_rx: RTL and testbench
================================

Name: bus_invert_rx

Overview:
- Receive end of the bus-invert (inverted-line) link. The transmit side drives either the word or its bitwise complement, plus an inversion flag.
- This block restores the true word (Out_Data = In_Inv ? ~In_Data : In_Data) and registers it.
- Buffers up to two words behind a valid/ready handshake and counts inverted words received.
- Sits between the link input pins/synchronisers and the consumer datapath.

Parameters:
- WIDTH, 8, data word width in bits (>=1)
- CNT_W, 16, width of the inverted-word statistics counter (>=1)

Ports:
- Clk  in  1  rising-edge clock, single clock domain
- Rst_n  in  1  asynchronous active-low reset
- In_Valid  in  1  link word present
- In_Ready  out  1  block can accept a word this cycle
- In_Data  in  WIDTH  link word, possibly inverted
- In_Inv  in  1  1 = In_Data is complemented
- Out_Valid  out  1  restored word available
- Out_Ready  in  1  consumer accepts Out_Data this cycle
- Out_Data  out  WIDTH  restored (true) word
- Clr_Cnt  in  1  synchronous clear of Inv_Cnt (and Par_Err when present)
- Inv_Cnt  out  CNT_W  saturating count of accepted words with In_Inv=1

Behaviour:
- Reset (Rst_n=0, async): state EMPTY, In_Ready=0, Out_Valid=0, Out_Data=0, Inv_Cnt=0. In_Ready goes 1 on the first clock edge after reset release.
- Accept = In_Valid & In_Ready. Emit = Out_Valid & Out_Ready. All outputs are registered; no combinational path from In_* to Out_*, or from Out_Ready to In_Ready.
- Decode happens on entry: the stored word is In_Inv ? ~In_Data : In_Data.
- Storage: main register M (drives Out_Data) and skid register S.
- State EMPTY:
  - Accept -> ONE; M <= decoded word.
- State ONE:
  - Accept & Emit -> ONE; M <= new word.
  - Accept & !Emit -> FULL; S <= new word.
  - !Accept & Emit -> EMPTY.
  - Otherwise hold.
- State FULL:
  - In_Ready=0, so no accept is possible.
  - Emit -> ONE; M <= S.
  - Otherwise hold.
- Output flags: Out_Valid = (state != EMPTY). In_Ready = (next state != FULL), registered.
- Latency: 1 cycle from accept to Out_Valid when EMPTY. Full throughput is 1 word/cycle with Out_Ready held high.
- Ordering: words leave strictly in arrival order; no drop, no duplication.
- Holding rules:
  - While Out_Valid=1 and Out_Ready=0, Out_Data is stable.
  - In_Data and In_Inv are ignored when Accept=0.
- Inv_Cnt:
  - Increments by 1 on Accept with In_Inv=1.
  - Saturates at all-ones (no wrap).
  - Clr_Cnt=1 forces 0 next cycle and wins over a same-cycle increment.
- Reset mid-operation: buffered words are discarded; there is no replay.

Optional Feature:
- Macro BUS_INV_PARITY_EN.
- When defined:
  - Adds port In_Par (in, 1): even parity over {In_Data, In_Inv, In_Par} as transmitted.
  - Adds port Par_Err (out, 1): sticky error flag, reset 0.
  - Par_Err is set on any Accept with odd parity and cleared by Clr_Cnt; set wins over clear in the same cycle.
  - The word is forwarded regardless of parity.
- When undefined: neither port exists and behaviour is otherwise identical.

Decomposition:
- Shared include/package bus_inv_defs:
  - State encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
  - Default WIDTH.
  - Shared with the matching transmit block.
- One sub-module, bi_skid_buf (parameter WIDTH):
  - Generic 2-entry valid/ready skid buffer holding the state machine and M/S.
- The top level contains the decode XOR, Inv_Cnt and the parity logic.

Test Plan:
- Reset release, In_Valid=1, In_Data=8'hA5, In_Inv=0 -> In_Ready=1 one cycle after release; Out_Data=8'hA5 with Out_Valid=1 one cycle after accept; Inv_Cnt=0.
- In_Data=8'h0F, In_Inv=1, Out_Ready=1 -> Out_Data=8'hF0; Inv_Cnt=1.
- Out_Ready=0, send 8'h11 then 8'h22 -> In_Ready=0 after the 2nd accept, Out_Data holds 8'h11. Then raise Out_Ready -> 8'h11, 8'h22 emitted in order and In_Ready returns to 1.
- Streaming 256 words, Out_Ready=1, alternating In_Inv -> one word per cycle, all decoded correctly, Inv_Cnt=128.
- CNT_W=2: four inverted accepts -> Inv_Cnt=3 (saturated). Clr_Cnt asserted with a simultaneous inverted accept -> Inv_Cnt=0.
- BUS_INV_PARITY_EN defined: accept with bad In_Par -> Par_Err=1 next cycle, word still output; Clr_Cnt -> Par_Err=0. Rst_n pulse while FULL -> Out_Valid=0 immediately.

Source files
------------

// File: rtl/bus_inv_defs.sv
// Shared definitions for the bus-invert link (rx and tx ends).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_inv_defs;

  // Default link word width.
  localparam int DEF_WIDTH = 8;

  // Two-entry skid buffer occupancy.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_st_t;

endpackage

// File: rtl/bi_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: main register M drives out_data, S catches overflow.
// Latency: 1 cycle from accept to out_valid when empty; 1 word/cycle with out_ready held high.
// Backpressure: in_ready is registered (next state != FULL); no comb path out_ready -> in_ready.
//
// Ports: clk, rst_n (async, active low); in_valid/in_ready/in_data upstream;
//        out_valid/out_ready/out_data downstream.
module bi_skid_buf
  import bus_inv_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  buf_st_t          state_q;
  buf_st_t          state_d;
  logic             in_ready_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] s_q;

  logic accept;
  logic emit;
  logic load_m_in;
  logic load_m_s;
  logic load_s;

  assign accept = in_valid & in_ready_q;
  assign emit   = (state_q != ST_EMPTY) & out_ready;

  // State register, plus the registered ready which looks one state ahead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_ONE;
      ST_ONE: begin
        if (accept && !emit)      state_d = ST_FULL;
        else if (!accept && emit) state_d = ST_EMPTY;
      end
      ST_FULL:  if (emit) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Output / datapath control decode.
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    load_m_in = 1'b0;
    load_m_s  = 1'b0;
    load_s    = 1'b0;
    case (state_q)
      ST_EMPTY: load_m_in = accept;
      ST_ONE: begin
        load_m_in = accept & emit;
        load_s    = accept & ~emit;
      end
      ST_FULL:  load_m_s = emit;
      default: ;
    endcase
  end

  // Storage. M only changes on load, so out_data is stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
      s_q <= '0;
    end else begin
      if (load_m_in)     m_q <= in_data;
      else if (load_m_s) m_q <= s_q;
      if (load_s)        s_q <= in_data;
    end
  end

  assign in_ready = in_ready_q;
  assign out_data = m_q;

endmodule

// File: rtl/bus_invert_rx.sv
// Bus-invert link receiver: restores the true word, buffers 2 words, counts inverted words.
// Latency: 1 cycle from accept to Out_Valid when empty; 1 word/cycle streaming.
// Backpressure: In_Ready registered, drops when both buffer entries are occupied.
//
// Ports: Clk, Rst_n (async, active low); In_Valid/In_Ready/In_Data/In_Inv link side;
//        Out_Valid/Out_Ready/Out_Data consumer side; Clr_Cnt, Inv_Cnt statistics.
// Optional: BUS_INV_PARITY_EN adds In_Par (even parity over {In_Data,In_Inv,In_Par})
//           and sticky Par_Err.
module bus_invert_rx
  import bus_inv_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] In_Data,
  input  logic             In_Inv,
`ifdef BUS_INV_PARITY_EN
  input  logic             In_Par,
  output logic             Par_Err,
`endif
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Out_Data,
  input  logic             Clr_Cnt,
  output logic [CNT_W-1:0] Inv_Cnt
);

  logic [WIDTH-1:0] decoded;
  logic             accept;
  logic [CNT_W-1:0] inv_cnt_q;

  // Decode on entry so both buffer entries hold true words.
  assign decoded = In_Data ^ {WIDTH{In_Inv}};
  assign accept  = In_Valid & In_Ready;

  bi_skid_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .in_valid  (In_Valid),
    .in_ready  (In_Ready),
    .in_data   (decoded),
    .out_valid (Out_Valid),
    .out_ready (Out_Ready),
    .out_data  (Out_Data)
  );

  // Saturating inverted-word counter; clear beats a same-cycle increment.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      inv_cnt_q <= '0;
    end else if (Clr_Cnt) begin
      inv_cnt_q <= '0;
    end else if (accept && In_Inv && (inv_cnt_q != {CNT_W{1'b1}})) begin
      inv_cnt_q <= inv_cnt_q + CNT_W'(1);
    end
  end

  assign Inv_Cnt = inv_cnt_q;

`ifdef BUS_INV_PARITY_EN
  logic par_odd;
  logic par_err_q;

  assign par_odd = ^{In_Data, In_Inv, In_Par};

  // Sticky error; a new error beats a same-cycle clear so it is never lost.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      par_err_q <= 1'b0;
    end else if (accept && par_odd) begin
      par_err_q <= 1'b1;
    end else if (Clr_Cnt) begin
      par_err_q <= 1'b0;
    end
  end

  assign Par_Err = par_err_q;
`endif

endmodule

// File: tb/tb_bus_invert_rx.sv
module tb_bus_invert_rx;

  logic       Clk;
  logic       Rst_n;
  logic       In_Valid;
  logic       In_Ready;
  logic [7:0] In_Data;
  logic       In_Inv;
  logic       Out_Valid;
  logic       Out_Ready;
  logic [7:0] Out_Data;
  logic       Clr_Cnt;
  logic [15:0] Inv_Cnt;

  // Second instance with a 2-bit counter, same stimulus, for saturation.
  logic       sat_in_ready;
  logic       sat_out_valid;
  logic [7:0] sat_out_data;
  logic [1:0] sat_inv_cnt;

`ifdef BUS_INV_PARITY_EN
  logic In_Par;
  logic Par_Err;
  logic sat_par_err;
`endif

  int n_chk;
  int n_fail;

  bus_invert_rx #(.WIDTH(8), .CNT_W(16)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .In_Data   (In_Data),
    .In_Inv    (In_Inv),
`ifdef BUS_INV_PARITY_EN
    .In_Par    (In_Par),
    .Par_Err   (Par_Err),
`endif
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Out_Data  (Out_Data),
    .Clr_Cnt   (Clr_Cnt),
    .Inv_Cnt   (Inv_Cnt)
  );

  bus_invert_rx #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In_Valid  (In_Valid),
    .In_Ready  (sat_in_ready),
    .In_Data   (In_Data),
    .In_Inv    (In_Inv),
`ifdef BUS_INV_PARITY_EN
    .In_Par    (In_Par),
    .Par_Err   (sat_par_err),
`endif
    .Out_Valid (sat_out_valid),
    .Out_Ready (Out_Ready),
    .Out_Data  (sat_out_data),
    .Clr_Cnt   (Clr_Cnt),
    .Inv_Cnt   (sat_inv_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int errs;
    logic [7:0] d;
    logic [7:0] e;

    n_chk     = 0;
    n_fail    = 0;
    Rst_n     = 1'b0;
    In_Valid  = 1'b0;
    In_Data   = 8'h00;
    In_Inv    = 1'b0;
    Out_Ready = 1'b0;
    Clr_Cnt   = 1'b0;
`ifdef BUS_INV_PARITY_EN
    In_Par    = 1'b0;
`endif

    step();
    step();
    chk("rst_in_ready",  In_Ready,  0);
    chk("rst_out_valid", Out_Valid, 0);
    chk("rst_out_data",  Out_Data,  8'h00);
    chk("rst_inv_cnt",   Inv_Cnt,   0);
    chk("rst_sat_ready", sat_in_ready, 0);
`ifdef BUS_INV_PARITY_EN
    chk("rst_par_err",   Par_Err,   0);
`endif

    // First word after reset release.
    In_Valid = 1'b1; In_Data = 8'hA5; In_Inv = 1'b0;
    Rst_n = 1'b1;
    step();
    chk("rel_in_ready",  In_Ready,  1);
    chk("rel_out_valid", Out_Valid, 0);
    step();
    chk("a5_out_valid", Out_Valid, 1);
    chk("a5_out_data",  Out_Data,  8'hA5);
    chk("a5_inv_cnt",   Inv_Cnt,   0);

    // Inverted word while the consumer drains A5.
    In_Data = 8'h0F; In_Inv = 1'b1; Out_Ready = 1'b1;
    step();
    chk("0f_out_data", Out_Data, 8'hF0);
    chk("0f_inv_cnt",  Inv_Cnt,  1);
    In_Valid = 1'b0;
    step();
    chk("drain_out_valid", Out_Valid, 0);

    // Fill both entries with the consumer stalled.
    Out_Ready = 1'b0;
    In_Valid = 1'b1; In_Data = 8'h11; In_Inv = 1'b0;
    step();
    chk("fill1_in_ready", In_Ready, 1);
    In_Data = 8'h22;
    step();
    chk("full_in_ready", In_Ready, 0);
    chk("full_out_data", Out_Data, 8'h11);
    In_Data = 8'h33; In_Inv = 1'b1;   // offered while not ready: must be ignored
    step();
    chk("hold_out_data", Out_Data, 8'h11);
    chk("hold_in_ready", In_Ready, 0);
    chk("hold_inv_cnt",  Inv_Cnt,  1);
    In_Valid = 1'b0; Out_Ready = 1'b1;
    step();
    chk("order2_out_data", Out_Data, 8'h22);
    chk("order2_in_ready", In_Ready, 1);
    step();
    chk("order_empty", Out_Valid, 0);

    // Stream 256 words, alternating inversion.
    Clr_Cnt = 1'b1;
    step();
    Clr_Cnt = 1'b0;
    chk("clr_inv_cnt", Inv_Cnt, 0);
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      d = 8'(i);
      if (In_Ready !== 1'b1) errs++;
      In_Valid = 1'b1; In_Data = d; In_Inv = d[0];
      step();
      e = d[0] ? ~d : d;
      if (Out_Valid !== 1'b1 || Out_Data !== e) errs++;
      if (sat_out_data !== e) errs++;
    end
    In_Valid = 1'b0;
    chk("stream_errs",    errs,        0);
    chk("stream_inv_cnt", Inv_Cnt,     128);
    chk("stream_sat_cnt", sat_inv_cnt, 3);
    chk("stream_last",    Out_Data,    8'h00);
    step();
    chk("stream_empty", Out_Valid, 0);

    // Saturation from zero: four inverted accepts.
    Clr_Cnt = 1'b1;
    step();
    Clr_Cnt = 1'b0;
    chk("sat_clr", sat_inv_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      In_Valid = 1'b1; In_Data = 8'h3C; In_Inv = 1'b1;
      step();
    end
    In_Valid = 1'b0;
    chk("sat_cnt4",  sat_inv_cnt, 3);
    chk("main_cnt4", Inv_Cnt,     4);
    chk("sat_data",  Out_Data,    8'hC3);

    // Clear wins over a same-cycle inverted accept.
    In_Valid = 1'b1; In_Data = 8'h55; In_Inv = 1'b1; Clr_Cnt = 1'b1;
    step();
    In_Valid = 1'b0; Clr_Cnt = 1'b0;
    chk("clrwin_cnt",  Inv_Cnt,     0);
    chk("clrwin_sat",  sat_inv_cnt, 0);
    chk("clrwin_data", Out_Data,    8'hAA);
    step();

`ifdef BUS_INV_PARITY_EN
    // {01,0,0} has odd parity -> error, word still delivered.
    In_Valid = 1'b1; In_Data = 8'h01; In_Inv = 1'b0; In_Par = 1'b0;
    step();
    chk("par_bad_err",  Par_Err,  1);
    chk("par_bad_data", Out_Data, 8'h01);
    // {03,0,0} even parity -> flag stays set.
    In_Data = 8'h03;
    step();
    chk("par_sticky", Par_Err, 1);
    In_Valid = 1'b0; Clr_Cnt = 1'b1;
    step();
    Clr_Cnt = 1'b0;
    chk("par_clr", Par_Err, 0);
    // Set wins over clear: {07,1,1} -> 5 ones, odd.
    In_Valid = 1'b1; In_Data = 8'h07; In_Inv = 1'b1; In_Par = 1'b1; Clr_Cnt = 1'b1;
    step();
    In_Valid = 1'b0; Clr_Cnt = 1'b0; In_Par = 1'b0;
    chk("par_setwin",      Par_Err,  1);
    chk("par_setwin_data", Out_Data, 8'hF8);
    step();
`endif

    // Reset pulse while FULL discards everything at once.
    Out_Ready = 1'b0;
    In_Valid = 1'b1; In_Inv = 1'b0; In_Data = 8'h44;
    step();
    In_Data = 8'h55;
    step();
    In_Valid = 1'b0;
    chk("prerst_in_ready", In_Ready, 0);
    Rst_n = 1'b0;
    #1;
    chk("arst_out_valid", Out_Valid, 0);
    chk("arst_out_data",  Out_Data,  8'h00);
    chk("arst_inv_cnt",   Inv_Cnt,   0);
`ifdef BUS_INV_PARITY_EN
    chk("arst_par_err",   Par_Err,   0);
`endif
    Out_Ready = 1'b1;
    step();
    Rst_n = 1'b1;
    step();
    step();
    chk("norep_out_valid", Out_Valid, 0);
    chk("norep_in_ready",  In_Ready,  1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
